// File: rtl/main_memory_pkg.sv
`default_nettype none
// ============================================================================
// Module      : main_memory_pkg
// Description : Shared types and constants for the main-memory controller.
// Revision    : 1.0 - initial release
// ============================================================================
package main_memory_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef logic [31:0] word_t;
    typedef logic [31:0] addr_t;

    localparam word_t OOR_DATA_DEFAULT = 32'hDEAD_BEEF;
    localparam int    LATENCY_MAX      = 255;
    localparam int    CNT_W            = 8;

    // Any byte-address bit above the word index makes the access out of range.
    function automatic logic addr_out_of_range(input addr_t addr, input int unsigned addr_w);
        return (addr >> (addr_w + 2)) != '0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_sram_1p.sv
`default_nettype none
// ============================================================================
// Module      : mem_sram_1p
// Description : Single-port synchronous RAM, one read or one write per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_sram_1p #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              i_en,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    localparam int c_DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [c_DEPTH];

    // Contents are intentionally not reset; the read register holds between reads.
    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we) begin
                r_mem[i_addr] <= i_wdata;
            end else begin
                o_rdata <= r_mem[i_addr];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/main_memory_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : main_memory_ctrl
// Description : Word-organised memory controller with programmable latency.
//               Define MEM_WRITE_POST_EN for the one-entry posted-write buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module main_memory_ctrl
    import main_memory_pkg::*;
#(
    parameter int    ADDR_W   = 10,
    parameter int    LATENCY  = 4,
    parameter word_t OOR_DATA = OOR_DATA_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_req,
    input  logic        mem_rw,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_data_in,
    output logic [31:0] mem_data_out,
    output logic        mem_ready
);

    localparam logic [CNT_W-1:0] c_LAT_M1 = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] c_ONE    = CNT_W'(1);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_rw;
    logic               r_oor;
    logic               r_ready;
    word_t              r_hold;

    logic               w_oor;
    logic [ADDR_W-1:0]  w_idx;
    logic               w_accept;
    logic               w_commit;
    logic               w_fast;
    logic               w_rd_issue;
    logic               w_ram_we;
    logic               w_ram_en;
    logic [ADDR_W-1:0]  w_ram_addr;
    logic [ADDR_W-1:0]  w_commit_idx;
    word_t              w_commit_data;
    word_t              w_ram_q;
    word_t              w_rdata_sel;

    assign w_oor = addr_out_of_range(mem_addr, ADDR_W);
    assign w_idx = mem_addr[ADDR_W+1:2];

`ifdef MEM_WRITE_POST_EN
    logic               r_post_valid;
    logic [CNT_W-1:0]   r_post_cnt;
    logic [ADDR_W-1:0]  r_post_idx;
    word_t              r_post_data;
    logic               r_fwd;

    // A read may not take the RAM port on the commit edge; a new write may,
    // since it only loads the buffer.
    assign w_commit      = r_post_valid && (r_post_cnt == '0);
    assign w_commit_idx  = r_post_idx;
    assign w_commit_data = r_post_data;
    assign w_accept      = (r_state == ST_IDLE) && mem_req &&
                           (mem_rw ? (!r_post_valid || w_commit) : !w_commit);
    assign w_fast        = mem_rw || (LATENCY == 1);
    assign w_rdata_sel   = r_oor ? OOR_DATA : (r_fwd ? r_post_data : w_ram_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_post_valid <= 1'b0;
            r_post_cnt   <= '0;
            r_post_idx   <= '0;
            r_post_data  <= '0;
        end else if (w_accept && mem_rw && !w_oor) begin
            r_post_valid <= 1'b1;
            r_post_cnt   <= c_LAT_M1;
            r_post_idx   <= w_idx;
            r_post_data  <= mem_data_in;
        end else if (w_commit) begin
            r_post_valid <= 1'b0;
        end else if (r_post_valid) begin
            r_post_cnt   <= r_post_cnt - c_ONE;
        end
    end
`else
    logic [ADDR_W-1:0]  r_idx;
    word_t              r_wdata;

    assign w_commit      = (r_state == ST_RESP) && r_rw && !r_oor;
    assign w_commit_idx  = r_idx;
    assign w_commit_data = r_wdata;
    assign w_accept      = (r_state == ST_IDLE) && mem_req;
    assign w_fast        = (LATENCY == 1);
    assign w_rdata_sel   = r_oor ? OOR_DATA : w_ram_q;
`endif

    // Reads hit the RAM at acceptance so the data is ready even for LATENCY==1.
    assign w_ram_we   = w_commit && !reset;
    assign w_rd_issue = w_accept && !mem_rw && !w_oor;
    assign w_ram_en   = w_ram_we || w_rd_issue;
    assign w_ram_addr = w_ram_we ? w_commit_idx : w_idx;

    mem_sram_1p #(
        .ADDR_W (ADDR_W),
        .DATA_W (32)
    ) u_sram (
        .clk     (clk),
        .i_en    (w_ram_en),
        .i_we    (w_ram_we),
        .i_addr  (w_ram_addr),
        .i_wdata (w_commit_data),
        .o_rdata (w_ram_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_rw    <= 1'b0;
            r_oor   <= 1'b0;
            r_ready <= 1'b0;
            r_hold  <= '0;
`ifdef MEM_WRITE_POST_EN
            r_fwd   <= 1'b0;
`else
            r_idx   <= '0;
            r_wdata <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_rw  <= mem_rw;
                        r_oor <= w_oor;
`ifdef MEM_WRITE_POST_EN
                        r_fwd <= !mem_rw && r_post_valid && (r_post_idx == w_idx);
`else
                        r_idx   <= w_idx;
                        r_wdata <= mem_data_in;
`endif
                        if (w_fast) begin
                            r_state <= ST_RESP;
                            r_ready <= 1'b1;
                            r_cnt   <= '0;
                        end else begin
                            r_state <= ST_BUSY;
                            r_cnt   <= c_LAT_M1;
                        end
                    end
                end
                ST_BUSY: begin
                    r_cnt <= r_cnt - c_ONE;
                    if (r_cnt == c_ONE) begin
                        r_state <= ST_RESP;
                        r_ready <= 1'b1;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b0;
                    if (!r_rw) begin
                        r_hold <= w_rdata_sel;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    assign mem_ready    = r_ready;
    assign mem_data_out = ((r_state == ST_RESP) && !r_rw) ? w_rdata_sel : r_hold;

endmodule
`default_nettype wire

// File: tb/tb_main_memory_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_main_memory_ctrl
// Description : Directed, table-driven bench for main_memory_ctrl (LATENCY 4 and 1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_main_memory_ctrl;

    localparam int c_LAT = 4;
`ifdef MEM_WRITE_POST_EN
    localparam int c_W2W_LAT = 3;
    localparam logic c_POST = 1'b1;
`else
    localparam int c_W2W_LAT = c_LAT;
    localparam logic c_POST = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        req4;
    logic        req1;
    logic        mem_rw;
    logic [31:0] mem_addr;
    logic [31:0] mem_data_in;
    logic [31:0] dout4;
    logic [31:0] dout1;
    logic        rdy4;
    logic        rdy1;

    int n_chk;
    int n_fail;

    main_memory_ctrl #(.ADDR_W(10), .LATENCY(c_LAT), .OOR_DATA(32'hDEAD_BEEF)) dut4 (
        .clk(clk), .reset(reset), .mem_req(req4), .mem_rw(mem_rw), .mem_addr(mem_addr),
        .mem_data_in(mem_data_in), .mem_data_out(dout4), .mem_ready(rdy4)
    );

    main_memory_ctrl #(.ADDR_W(10), .LATENCY(1), .OOR_DATA(32'hDEAD_BEEF)) dut1 (
        .clk(clk), .reset(reset), .mem_req(req1), .mem_rw(mem_rw), .mem_addr(mem_addr),
        .mem_data_in(mem_data_in), .mem_data_out(dout1), .mem_ready(rdy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        rw;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        chk;
        logic [31:0] exp;
    } vec_t;

    localparam int c_NV = 13;
    vec_t vecs [c_NV];

    function automatic int exp_lat(input logic rw, input int lat);
        return (rw && c_POST) ? 1 : lat;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Entered and left on a falling edge; counts cycles from presentation to ready.
    task automatic access(input int sel, input logic rw, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic chk, input logic [31:0] exp,
                          input int lat, input string name);
        int          cyc;
        logic        got;
        logic [31:0] d;
        mem_rw      = rw;
        mem_addr    = addr;
        mem_data_in = wdata;
        if (sel == 1) req1 = 1'b1; else req4 = 1'b1;
        cyc = 0;
        got = 1'b0;
        d   = '0;
        while (!got && cyc < 40) begin
            @(negedge clk);
            cyc++;
            got = (sel == 1) ? rdy1 : rdy4;
            d   = (sel == 1) ? dout1 : dout4;
        end
        req1 = 1'b0;
        req4 = 1'b0;
        check({name, "_ready_seen"}, {31'b0, got}, 32'd1);
        if (got) begin
            check({name, "_latency"}, cyc, lat);
            if (chk && !rw) check({name, "_data"}, d, exp);
        end
        @(negedge clk);
        check({name, "_ready_width"}, {31'b0, ((sel == 1) ? rdy1 : rdy4)}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_chk = 0;
        n_fail = 0;
        reset = 1'b1;
        req4 = 1'b0;
        req1 = 1'b0;
        mem_rw = 1'b0;
        mem_addr = '0;
        mem_data_in = '0;

        vecs[0]  = '{1'b0, 32'h0000_0010, 32'h0,          1'b0, 32'h0};
        vecs[1]  = '{1'b1, 32'h0000_0040, 32'h1234_5678,  1'b0, 32'h0};
        vecs[2]  = '{1'b0, 32'h0000_0040, 32'h0,          1'b1, 32'h1234_5678};
        vecs[3]  = '{1'b1, 32'h0000_0000, 32'h0BAD_F00D,  1'b0, 32'h0};
        vecs[4]  = '{1'b0, 32'h8000_0000, 32'h0,          1'b1, 32'hDEAD_BEEF};
        vecs[5]  = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF,  1'b0, 32'h0};
        vecs[6]  = '{1'b0, 32'h0000_0000, 32'h0,          1'b1, 32'h0BAD_F00D};
        vecs[7]  = '{1'b1, 32'h0000_1000, 32'h2222_2222,  1'b0, 32'h0};
        vecs[8]  = '{1'b0, 32'h0000_0000, 32'h0,          1'b1, 32'h0BAD_F00D};
        vecs[9]  = '{1'b1, 32'h0000_0080, 32'h5555_AAAA,  1'b0, 32'h0};
        vecs[10] = '{1'b0, 32'h0000_0083, 32'h0,          1'b1, 32'h5555_AAAA};
        vecs[11] = '{1'b1, 32'h0000_0FFC, 32'h1357_9BDF,  1'b0, 32'h0};
        vecs[12] = '{1'b0, 32'h0000_0FFC, 32'h0,          1'b1, 32'h1357_9BDF};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_ready4", {31'b0, rdy4}, 32'd0);
        check("rst_dout4", dout4, 32'd0);
        check("rst_ready1", {31'b0, rdy1}, 32'd0);
        check("rst_dout1", dout1, 32'd0);

        for (int i = 0; i < c_NV; i++) begin
            access(0, vecs[i].rw, vecs[i].addr, vecs[i].wdata, vecs[i].chk, vecs[i].exp,
                   exp_lat(vecs[i].rw, c_LAT), $sformatf("vec%0d", i));
        end

        // Reset lands two edges into a write to 0x80: nothing may be committed.
        mem_rw = 1'b1;
        mem_addr = 32'h0000_0080;
        mem_data_in = 32'hDEAD_0080;
        req4 = 1'b1;
        @(negedge clk);
        check("t4_ready_n1", {31'b0, rdy4}, {31'b0, c_POST});
        @(negedge clk);
        req4 = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("t4_ready_rst", {31'b0, rdy4}, 32'd0);
        check("t4_dout_rst", dout4, 32'd0);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("t4_no_ready%0d", k), {31'b0, rdy4}, 32'd0);
        end
        access(0, 1'b0, 32'h0000_0080, 32'h0, 1'b1, 32'h5555_AAAA, c_LAT, "t4_read80");

        // Posted-write behaviour (full latency when posting is disabled).
        access(0, 1'b1, 32'h0000_0020, 32'hA5A5_A5A5, 1'b0, 32'h0, exp_lat(1'b1, c_LAT), "t6_w20");
        access(0, 1'b0, 32'h0000_0020, 32'h0, 1'b1, 32'hA5A5_A5A5, c_LAT, "t6_r20");
        access(0, 1'b1, 32'h0000_0024, 32'h2424_0001, 1'b0, 32'h0, exp_lat(1'b1, c_LAT), "t6_w24");
        access(0, 1'b1, 32'h0000_0028, 32'h2828_0002, 1'b0, 32'h0, c_W2W_LAT, "t6_w28_stall");
        access(0, 1'b0, 32'h0000_0024, 32'h0, 1'b1, 32'h2424_0001, c_LAT, "t6_r24");
        access(0, 1'b0, 32'h0000_0028, 32'h0, 1'b1, 32'h2828_0002, c_LAT, "t6_r28");

        // LATENCY=1 with the request held: one ready every second cycle.
        access(1, 1'b1, 32'h0000_0004, 32'h1111_0004, 1'b0, 32'h0, 1, "t5_w4");
        mem_rw = 1'b0;
        mem_addr = 32'h0000_0004;
        req1 = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            check($sformatf("t5_ready_c%0d", k), {31'b0, rdy1}, {31'b0, (k % 2) == 1});
            if ((k % 2) == 1) check($sformatf("t5_data_c%0d", k), dout1, 32'h1111_0004);
            if (k == 6) req1 = 1'b0;
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check($sformatf("t5_idle%0d", k), {31'b0, rdy1}, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
